pcounter_mc: RTL and testbench

Multi-channel programmable counter bank, the parametrised successor to the single-channel configurable counter. NUM_CH independent WIDTH-bit counters share one SRAM-like configuration port. Each channel supports up, down, bounce (up/down ping-pong) and suspend modes, a per-channel count-enable input, a wrap event output and a sticky status register. It sits beside the existing counter in the test/stimulus infrastructure as a general timer/sequence source.

---
 rtl/pcounter_mc.sv | 177 +++++++++++++++++
 tb/tb_pcounter_mc.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/pcounter_mc.sv
// pcounter_mc: bank of NUM_CH programmable up/down/bounce counters
// sharing one CSR port with registered read data.
module pcounter_mc #(
  parameter int NUM_CH   = 4,
  parameter int WIDTH    = 10,
  parameter int DEF_MIN  = 10,
  parameter int DEF_MAX  = 100,
  parameter int DEF_STEP = 1,
  localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cfg_enable,
  input  logic                    cfg_rd_wr,
  input  logic [CH_W+2:0]         cfg_addr,
  input  logic [WIDTH-1:0]        cfg_wdata,
  output logic [WIDTH-1:0]        cfg_rdata,
  output logic                    cfg_rvalid,
  input  logic [NUM_CH-1:0]       cnt_en_i,
  output logic [NUM_CH*WIDTH-1:0] counter_o,
  output logic [NUM_CH*2-1:0]     curr_state_o,
  output logic [NUM_CH-1:0]       wrap_o
);

  typedef enum logic [1:0] {
    M_UP   = 2'b00,
    M_DOWN = 2'b01,
    M_SUSP = 2'b10,
    M_BNC  = 2'b11
  } mode_e;

  mode_e            mode_q [NUM_CH];
  logic [WIDTH-1:0] min_q  [NUM_CH];
  logic [WIDTH-1:0] max_q  [NUM_CH];
  logic [WIDTH-1:0] step_q [NUM_CH];
  logic [WIDTH-1:0] cnt_q  [NUM_CH];
  logic [WIDTH-1:0] cnt_d  [NUM_CH];
  logic [NUM_CH-1:0] en_q, dir_q, dir_d;
  logic [NUM_CH-1:0] sticky_q, wrap_q;
  logic [NUM_CH-1:0] adv, hit, fire, wr_hit, err;
  logic [WIDTH-1:0]  rdata_q, rdata_d;
  logic              rvalid_q;

  logic [CH_W-1:0] ch_sel;
  logic [2:0]      reg_sel;
  logic            rd_acc;
  logic [WIDTH:0]  sum_v, lo_v;
  logic            above_v, below_v;

  assign ch_sel  = cfg_addr[CH_W+2:3];
  assign reg_sel = cfg_addr[2:0];
  assign rd_acc  = cfg_enable & cfg_rd_wr;

  // Per-channel next count, direction and wrap, plus write decode.
  always_comb begin
    sum_v   = '0;
    lo_v    = '0;
    above_v = 1'b0;
    below_v = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      cnt_d[c] = cnt_q[c];
      dir_d[c] = dir_q[c];
      hit[c]   = 1'b0;
      err[c]   = min_q[c] > max_q[c];
      sum_v    = {1'b0, cnt_q[c]} + {1'b0, step_q[c]};
      lo_v     = {1'b0, min_q[c]} + {1'b0, step_q[c]};
      above_v  = sum_v > {1'b0, max_q[c]};
      below_v  = {1'b0, cnt_q[c]} < lo_v;
      case (mode_q[c])
        M_UP: begin
          hit[c]   = above_v;
          cnt_d[c] = above_v ? min_q[c] : sum_v[WIDTH-1:0];
        end
        M_DOWN: begin
          hit[c]   = below_v;
          cnt_d[c] = below_v ? max_q[c] : cnt_q[c] - step_q[c];
        end
        M_BNC: begin
          if (!dir_q[c]) begin
            hit[c]   = above_v;
            cnt_d[c] = above_v ? max_q[c] : sum_v[WIDTH-1:0];
            dir_d[c] = above_v;
          end else begin
            hit[c]   = below_v;
            cnt_d[c] = below_v ? min_q[c] : cnt_q[c] - step_q[c];
            dir_d[c] = ~below_v;
          end
        end
        default: ;
      endcase
      wr_hit[c] = cfg_enable & ~cfg_rd_wr & (ch_sel == CH_W'(c));
      adv[c]    = en_q[c] & cnt_en_i[c] & (mode_q[c] != M_SUSP) &
                  (step_q[c] != '0) & ~err[c] &
                  ~(wr_hit[c] & (reg_sel == 3'd4));
      fire[c]   = adv[c] & hit[c];
    end
  end

  // Read data mux; unmapped registers and channels return zero.
  always_comb begin
    rdata_d = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (ch_sel == CH_W'(c)) begin
        case (reg_sel)
          3'd0: rdata_d = {{(WIDTH-4){1'b0}}, dir_q[c], en_q[c], mode_q[c]};
          3'd1: rdata_d = min_q[c];
          3'd2: rdata_d = max_q[c];
          3'd3: rdata_d = step_q[c];
          3'd4: rdata_d = cnt_q[c];
          3'd5: rdata_d = {{(WIDTH-2){1'b0}}, err[c], sticky_q[c]};
          default: rdata_d = '0;
        endcase
      end
    end
  end

  // Channel state, CSR writes and registered read/wrap outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NUM_CH; c++) begin
        mode_q[c] <= M_UP;
        min_q[c]  <= WIDTH'(DEF_MIN);
        max_q[c]  <= WIDTH'(DEF_MAX);
        step_q[c] <= WIDTH'(DEF_STEP);
        cnt_q[c]  <= WIDTH'(DEF_MIN);
      end
      en_q     <= '1;
      dir_q    <= '0;
      sticky_q <= '0;
      wrap_q   <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rvalid_q <= rd_acc;
      if (rd_acc) rdata_q <= rdata_d;
      wrap_q <= fire;
      for (int c = 0; c < NUM_CH; c++) begin
        if (adv[c]) begin
          cnt_q[c] <= cnt_d[c];
          dir_q[c] <= dir_d[c];
        end
        if (fire[c]) sticky_q[c] <= 1'b1;
        else if (wr_hit[c] && reg_sel == 3'd5 && cfg_wdata[0])
          sticky_q[c] <= 1'b0;
        if (wr_hit[c]) begin
          case (reg_sel)
            3'd0: begin
              mode_q[c] <= mode_e'(cfg_wdata[1:0]);
              en_q[c]   <= cfg_wdata[2];
              dir_q[c]  <= 1'b0;
            end
            3'd1: min_q[c]  <= cfg_wdata;
            3'd2: max_q[c]  <= cfg_wdata;
            3'd3: step_q[c] <= cfg_wdata;
            3'd4: cnt_q[c]  <= cfg_wdata;
            default: ;
          endcase
        end
      end
    end
  end

  // Pack per-channel count and mode onto the flat output buses.
  always_comb begin
    counter_o    = '0;
    curr_state_o = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      counter_o[c*WIDTH +: WIDTH] = cnt_q[c];
      curr_state_o[2*c +: 2]      = mode_q[c];
    end
  end

  assign cfg_rdata  = rdata_q;
  assign cfg_rvalid = rvalid_q;
  assign wrap_o     = wrap_q;

endmodule

// File: tb/tb_pcounter_mc.sv
// tb_pcounter_mc: directed checks of the counter bank
// (five channels so an out-of-range channel index exists).
module tb_pcounter_mc;

  localparam int NCH = 5;
  localparam int W   = 10;
  localparam int CHW = 3;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           cfg_enable = 1'b0;
  logic           cfg_rd_wr = 1'b0;
  logic [CHW+2:0] cfg_addr = '0;
  logic [W-1:0]   cfg_wdata = '0;
  logic [W-1:0]   cfg_rdata;
  logic           cfg_rvalid;
  logic [NCH-1:0] cnt_en_i = '0;
  logic [NCH*W-1:0] counter_o;
  logic [NCH*2-1:0] curr_state_o;
  logic [NCH-1:0] wrap_o;

  int n_chk = 0;
  int n_err = 0;
  logic [W-1:0] rd;

  pcounter_mc #(.NUM_CH(NCH), .WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_enable(cfg_enable), .cfg_rd_wr(cfg_rd_wr),
    .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .cfg_rdata(cfg_rdata), .cfg_rvalid(cfg_rvalid),
    .cnt_en_i(cnt_en_i), .counter_o(counter_o),
    .curr_state_o(curr_state_o), .wrap_o(wrap_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int cnt(input int ch);
    return int'(counter_o[ch*W +: W]);
  endfunction

  task automatic cfg_wr(input int ch, input int r, input int d);
    @(negedge clk);
    cfg_enable = 1'b1;
    cfg_rd_wr  = 1'b0;
    cfg_addr   = {3'(ch), 3'(r)};
    cfg_wdata  = W'(d);
    @(negedge clk);
    cfg_enable = 1'b0;
  endtask

  task automatic cfg_rd(input int ch, input int r, output logic [W-1:0] d);
    @(negedge clk);
    cfg_enable = 1'b1;
    cfg_rd_wr  = 1'b1;
    cfg_addr   = {3'(ch), 3'(r)};
    @(negedge clk);
    cfg_enable = 1'b0;
    check("rvalid", int'(cfg_rvalid), 1);
    d = cfg_rdata;
  endtask

  task automatic tick(input int ch);
    @(negedge clk);
    cnt_en_i = NCH'(1 << ch);
    @(negedge clk);
    cnt_en_i = '0;
  endtask

  initial begin
    // 1: reset values, then a full up-count cycle on every channel
    repeat (2) @(negedge clk);
    check("rst cnt0", cnt(0), 10);
    check("rst wrap", int'(wrap_o), 0);
    check("rst rvalid", int'(cfg_rvalid), 0);
    check("rst state", int'(curr_state_o), 0);
    rst_n = 1'b1;
    @(negedge clk);
    cnt_en_i = '1;
    for (int i = 1; i <= 90; i++) begin
      @(negedge clk);
      check("up cnt0", cnt(0), 10 + i);
    end
    check("up nowrap", int'(wrap_o), 0);
    @(negedge clk);
    cnt_en_i = '0;
    check("up wrapcnt", cnt(0), 10);
    check("up wrap", int'(wrap_o), 5'h1f);
    @(negedge clk);
    check("up wrap1cyc", int'(wrap_o), 0);
    cfg_rd(0, 5, rd);
    check("up status", int'(rd), 1);
    @(negedge clk);
    check("rvalid pulse", int'(cfg_rvalid), 0);

    // 2: down mode on ch1
    cfg_wr(1, 1, 5);
    cfg_wr(1, 2, 20);
    cfg_wr(1, 3, 7);
    cfg_wr(1, 0, 3'b101);
    cfg_wr(1, 4, 20);
    tick(1);
    check("dn 13", cnt(1), 13);
    tick(1);
    check("dn 6", cnt(1), 6);
    check("dn nowrap", int'(wrap_o), 0);
    tick(1);
    check("dn 20", cnt(1), 20);
    check("dn wrap", int'(wrap_o), 5'b00010);
    cfg_rd(1, 4, rd);
    check("dn rdcnt", int'(rd), 20);

    // 3: bounce on ch2
    cfg_wr(2, 1, 0);
    cfg_wr(2, 2, 9);
    cfg_wr(2, 3, 4);
    cfg_wr(2, 0, 3'b111);
    cfg_wr(2, 4, 0);
    check("state bnc", int'(curr_state_o[5:4]), 3);
    tick(2);
    check("bn 4", cnt(2), 4);
    tick(2);
    check("bn 8", cnt(2), 8);
    tick(2);
    check("bn 9", cnt(2), 9);
    check("bn wrap hi", int'(wrap_o), 5'b00100);
    cfg_rd(2, 0, rd);
    check("bn ctrl dn", int'(rd), 4'b1111);
    tick(2);
    check("bn 5", cnt(2), 5);
    tick(2);
    check("bn 1", cnt(2), 1);
    tick(2);
    check("bn 0", cnt(2), 0);
    check("bn wrap lo", int'(wrap_o), 5'b00100);
    cfg_rd(2, 0, rd);
    check("bn ctrl up", int'(rd), 4'b0111);
    tick(2);
    check("bn 4b", cnt(2), 4);

    // 4: MIN > MAX freezes ch3
    cfg_wr(3, 5, 1);
    cfg_wr(3, 1, 50);
    cfg_wr(3, 2, 40);
    cfg_rd(3, 5, rd);
    check("err status", int'(rd), 2);
    repeat (3) tick(3);
    check("err frozen", cnt(3), 10);
    check("err nowrap", int'(wrap_o), 0);
    cfg_wr(3, 2, 60);
    cfg_rd(3, 5, rd);
    check("err clear", int'(rd), 0);
    tick(3);
    check("err resume", cnt(3), 11);

    // 5: COUNT write beats advance; wrap set beats W1C
    @(negedge clk);
    cnt_en_i   = 5'b00001;
    cfg_enable = 1'b1;
    cfg_rd_wr  = 1'b0;
    cfg_addr   = {3'd0, 3'd4};
    cfg_wdata  = 10'd33;
    @(negedge clk);
    cnt_en_i   = '0;
    cfg_enable = 1'b0;
    check("wr wins", cnt(0), 33);
    check("wr nowrap", int'(wrap_o), 0);
    cfg_wr(0, 5, 1);
    cfg_rd(0, 5, rd);
    check("w1c", int'(rd), 0);
    cfg_wr(0, 4, 100);
    @(negedge clk);
    cnt_en_i   = 5'b00001;
    cfg_enable = 1'b1;
    cfg_rd_wr  = 1'b0;
    cfg_addr   = {3'd0, 3'd5};
    cfg_wdata  = 10'd1;
    @(negedge clk);
    cnt_en_i   = '0;
    cfg_enable = 1'b0;
    check("set cnt", cnt(0), 10);
    check("set wrap", int'(wrap_o), 1);
    cfg_rd(0, 5, rd);
    check("set wins", int'(rd), 1);

    // 6: unmapped reads, then asynchronous reset mid-read
    cfg_rd(1, 6, rd);
    check("reg6", int'(rd), 0);
    cfg_rd(6, 1, rd);
    check("ch6", int'(rd), 0);
    cfg_rd(1, 1, rd);
    check("min1", int'(rd), 5);
    @(negedge clk);
    check("rdata hold", int'(cfg_rdata), 5);
    cnt_en_i = 5'b00001;
    repeat (3) @(negedge clk);
    check("pre rst", cnt(0), 13);
    cfg_enable = 1'b1;
    cfg_rd_wr  = 1'b1;
    cfg_addr   = {3'd1, 3'd2};
    #2;
    rst_n = 1'b0;
    #1;
    check("arst cnt0", cnt(0), 10);
    check("arst cnt2", cnt(2), 10);
    check("arst state", int'(curr_state_o), 0);
    check("arst rdata", int'(cfg_rdata), 0);
    check("arst rvalid", int'(cfg_rvalid), 0);
    check("arst wrap", int'(wrap_o), 0);
    @(negedge clk);
    check("arst norv", int'(cfg_rvalid), 0);
    cfg_enable = 1'b0;
    cnt_en_i   = '0;
    rst_n      = 1'b1;
    cfg_rd(1, 1, rd);
    check("arst min1", int'(rd), 10);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
